int_sync_gateway_arbiter: RTL

Interrupt gateway and priority arbiter for level interrupts that have already been synchronized into the local clock domain by an interrupt sync crossing. It latches each source into a pending bit and blocks that source from re-triggering until the handler completes. It selects the highest-priority eligible pending source and serves a claim/complete handshake to a single hart-side consumer.

---
 rtl/int_sync_gateway_arbiter.sv | 75 +++++++
 1 files changed

// File: rtl/int_sync_gateway_arbiter.sv
// Interrupt gateway and priority arbiter: latches synchronized level sources into
// pending bits, blocks re-triggering until completion, and serves claim/complete.
module int_sync_gateway_arbiter #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned PRIO_W = 2,
  parameter int unsigned ID_W   = $clog2(N_SRC + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        io_src,
  input  logic [N_SRC*PRIO_W-1:0] io_prio,
  input  logic [PRIO_W-1:0]       io_threshold,
  input  logic                    io_claim,
  input  logic                    io_complete,
  input  logic [ID_W-1:0]         io_complete_id,
  output logic                    io_irq,
  output logic                    io_claim_valid,
  output logic [ID_W-1:0]         io_claim_id
);

  logic [N_SRC-1:0]  armed;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  elig;
  logic [N_SRC-1:0]  armed_nxt;
  logic [N_SRC-1:0]  pending_nxt;
  logic [PRIO_W-1:0] best_prio;
  logic [ID_W-1:0]   winner;

  // Highest eligible priority wins; strict '>' keeps ties on the lowest index.
  always_comb begin : arbitrate
    elig      = '0;
    best_prio = '0;
    winner    = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      elig[i] = pending[i] && (io_prio[i*PRIO_W +: PRIO_W] > io_threshold);
      if (elig[i] && (io_prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = io_prio[i*PRIO_W +: PRIO_W];
        winner    = ID_W'(i + 1);
      end
    end
  end

  // Gateway accept, claim clear and completion re-arm, all from current-cycle state.
  always_comb begin : next_state
    pending_nxt = pending | (io_src & armed);
    armed_nxt   = armed & ~io_src;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (io_claim && (winner == ID_W'(i + 1))) begin
        pending_nxt[i] = 1'b0;
      end
      if (io_complete && (io_complete_id == ID_W'(i + 1)) && !armed[i] && !pending[i]) begin
        armed_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin : regs
    if (!reset) begin
      armed          <= '1;
      pending        <= '0;
      io_irq         <= 1'b0;
      io_claim_valid <= 1'b0;
      io_claim_id    <= '0;
    end else begin
      armed          <= armed_nxt;
      pending        <= pending_nxt;
      io_irq         <= |elig;
      io_claim_valid <= io_claim;
      if (io_claim) begin
        io_claim_id <= winner;
      end
    end
  end

endmodule
